// File: rtl/mont_core_scheduler.sv
// mont_core_scheduler: round-robin sharing of one serially loaded Montgomery core between two requesters
module mont_core_scheduler #(
   parameter int WORD_SIZE = 64,
   parameter int WORDS     = 32,
   parameter int TIMEOUT   = 1048576
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           rq_valid,
   input  logic [WORD_SIZE-1:0] rq_data0,
   input  logic [WORD_SIZE-1:0] rq_data1,
   output logic [1:0]           rq_ready,
   output logic [1:0]           cmp_done,
   output logic [1:0]           cmp_err,
   output logic                 busy,
   output logic                 core_reset,
   output logic [WORD_SIZE-1:0] core_bus,
   input  logic                 core_done
);
   localparam int JOB = 2 * WORDS;
   localparam int AW  = $clog2(JOB);
   localparam int IW  = AW + 1;
   localparam int TW  = $clog2(TIMEOUT) + 1;
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] COLLECT  = 3'd1;
   localparam logic [2:0] STREAM   = 3'd2;
   localparam logic [2:0] WAIT     = 3'd3;
   localparam logic [2:0] RESP_OK  = 3'd4;
   localparam logic [2:0] RESP_ERR = 3'd5;

   logic [2:0]           state;
   logic                 g, rr_last, g_next, hs;
   logic [1:0]           g_hot;
   logic [IW-1:0]        wr_idx, rd_idx;
   logic [TW-1:0]        timer;
   logic [WORD_SIZE-1:0] mem [JOB];

   always_comb begin
      g_next     = rq_valid[~rr_last] ? ~rr_last : rr_last;
      g_hot      = g ? 2'b10 : 2'b01;
      hs         = (state == COLLECT) && rq_valid[g];
      rq_ready   = (state == COLLECT) ? g_hot : 2'b00;
      cmp_done   = (state == RESP_OK) ? g_hot : 2'b00;
      cmp_err    = (state == RESP_ERR) ? g_hot : 2'b00;
      busy       = state != IDLE;
      core_reset = !((state == STREAM) || (state == WAIT));
      // Driven straight from the buffer so word k is stable for the whole k-th stream cycle
      core_bus   = (state == STREAM) ? mem[rd_idx[AW-1:0]] : '0;
   end

   always_ff @(posedge clk)
      if (hs) mem[wr_idx[AW-1:0]] <= g ? rq_data1 : rq_data0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         g       <= 1'b0;
         rr_last <= 1'b1;
         wr_idx  <= '0;
         rd_idx  <= '0;
         timer   <= '0;
      end else begin
         case (state)
            IDLE:
               if (|rq_valid) begin
                  g       <= g_next;
                  rr_last <= g_next;
                  wr_idx  <= '0;
                  state   <= COLLECT;
               end
            COLLECT:
               if (hs) begin
                  wr_idx <= wr_idx + 1'b1;
                  if (wr_idx == IW'(JOB - 1)) begin
                     rd_idx <= '0;
                     state  <= STREAM;
                  end
               end
            STREAM: begin
               rd_idx <= rd_idx + 1'b1;
               if (rd_idx == IW'(JOB - 1)) begin
                  timer <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               timer <= timer + 1'b1;
               // A done arriving on the timeout cycle still counts as success
               if (core_done) state <= RESP_OK;
               else if (timer == TW'(TIMEOUT - 1)) state <= RESP_ERR;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mont_core_scheduler.md
Name: mont_core_scheduler

Overview:
- Shares one 2048-bit Montgomery multiplier core between two requesters.
- The core has a fixed serial load: after its active-high reset drops, it samples one 64-bit bus word per clock, u words 0..31 then v words 0..31. It then computes and raises a sticky done.
- This block arbitrates requesters round-robin, buffers a requester's 64 operand words, holds the core in reset between jobs, and streams the buffer cycle-exact.
- It watches core done, enforces a timeout, and returns a per-requester completion or error pulse.

Parameters:
- WORD_SIZE, 64, bus/word width in bits
- WORDS, 32, words per operand (2048/64); a job is 2*WORDS words
- TIMEOUT, 1048576, maximum cycles from last streamed word to core_done before error

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- rq_valid  in  2  per-requester operand word valid; bit r belongs to requester r
- rq_data0  in  WORD_SIZE  requester 0 operand word
- rq_data1  in  WORD_SIZE  requester 1 operand word
- rq_ready  out  2  word accepted from requester r when rq_valid[r]&rq_ready[r]
- cmp_done  out  2  one-cycle pulse: job of requester r completed
- cmp_err  out  2  one-cycle pulse: job of requester r timed out
- busy  out  1  high in every state except IDLE
- core_reset  out  1  active-high reset to core; high while idle
- core_bus  out  WORD_SIZE  word presented to core
- core_done  in  1  sticky done from core; cleared only by core_reset

Behaviour:
- Reset values:
  - rq_ready=0, cmp_done=0, cmp_err=0, busy=0, core_reset=1, core_bus=0
  - state=IDLE, rr_last=1, so requester 0 wins first
  - Buffer contents are don't-care.
- Buffer: 2*WORDS x WORD_SIZE registers/RAM, write index wr_idx and read index rd_idx (each log2(2*WORDS)+1 bits). Word k holds u[k] for k<WORDS and v[k-WORDS] otherwise.
- IDLE:
  - core_reset=1.
  - If any rq_valid bit is high, grant g: the requester other than rr_last if it is valid, else the valid one.
  - Latch g, set rr_last=g, wr_idx=0, go to COLLECT.
- COLLECT:
  - rq_ready[g]=1, other ready bit 0.
  - On a handshake, write the word to buf[wr_idx] and increment wr_idx.
  - Stalls (valid low) are allowed; the grant holds until 2*WORDS words are accepted, then go to STREAM with rd_idx=0.
  - A non-granted requester's valid is ignored and it waits.
- STREAM:
  - core_reset=0 combinationally from state.
  - core_bus=buf[rd_idx] on every cycle of STREAM; rd_idx increments each cycle.
  - The core samples word k on the k-th posedge after core_reset falls, so word k must be stable at that edge.
  - No stall is permitted here; this is why data is buffered first.
  - After word 2*WORDS-1, go to WAIT, clear timer, core_bus=0.
- WAIT:
  - core_reset=0, timer increments.
  - If core_done=1, go to RESP_OK.
  - Else if timer==TIMEOUT-1, go to RESP_ERR.
  - If core_done and the timeout hit occur in the same cycle, done wins.
- RESP_OK: cmp_done[g]=1 for one cycle, core_reset=1, go to IDLE.
- RESP_ERR: cmp_err[g]=1 for one cycle, core_reset=1, go to IDLE.
- core_reset is 1 in IDLE/COLLECT/RESP states and 0 only in STREAM/WAIT. Every job therefore starts from a cleared core, and the sticky core_done is cleared before the next job.
- Minimum IDLE dwell is one cycle with core_reset=1 between consecutive jobs.
- The core's result register is not exported. Result readback is out of scope; cmp_done only signals completion.
- Both requesters valid in IDLE: alternate strictly by rr_last. Requester r that just finished loses to the other if both are waiting.
- Asynchronous reset mid-job: everything returns to reset values immediately and core_reset goes 1. The partially collected job is dropped with no cmp pulse, and requesters must resubmit.
- Spurious core_done outside WAIT is ignored.

Test Plan:
- Single job, requester 0: stream words 0x1..0x40 with continuous valid.
  - rq_ready[0] is high for exactly 64 cycles.
  - core_reset falls, and core_bus shows 0x1..0x40 on 64 consecutive cycles.
  - A core model raising done 100 cycles later gives cmp_done=2'b01 for one cycle; busy falls next cycle.
- Stalled collection: requester 1 drops valid every other cycle.
  - Collection takes 127 cycles.
  - Streaming is still 64 contiguous cycles with correct order.
- Contention: both valid in IDLE after reset.
  - Requester 0 is served first, then requester 1.
  - Requester 0 re-requests immediately; requester 1 still wins the second grant.
  - cmp_done order is 01, 10.
- Timeout: TIMEOUT=16, model never raises done.
  - cmp_err[g] pulses 16 cycles after the last streamed word; core_reset returns to 1.
  - The next job proceeds normally.
- Boundary: core_done rises on the same cycle as the timeout hit → cmp_done pulses and cmp_err stays 0.
- Reset mid-STREAM at word 20: outputs return to reset values asynchronously, no cmp pulse, and a new job completes correctly.
